// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with enable, channel mask and autonomous scan mode.
// Latency: 1 cycle from any sampled input to o/idx/valid/wrap; no combinational input-to-output path.
// Backpressure: none; free-running, outputs update every clock edge.
module scan_decoder #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        s,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic [(1<<SEL_W)-1:0]   mask,
  output logic [(1<<SEL_W)-1:0]   o,
  output logic [SEL_W-1:0]        idx,
  output logic                    valid,
  output logic                    wrap
);

  localparam int N = 1 << SEL_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_nxt;
  logic [SEL_W-1:0]   idx_nxt;
  logic [SEL_W-1:0]   lowest;
  logic [SEL_W-1:0]   above;
  logic               has_above;
  logic               any_set;
  logic               valid_nxt;
  logic               wrap_nxt;

  assign any_set = |mask;

  // Find the lowest enabled channel and the first enabled channel strictly above idx.
  always_comb begin
    lowest    = '0;
    above     = '0;
    has_above = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = SEL_W'(i);
      end
      if (mask[i] && (i > int'(idx))) begin
        above     = SEL_W'(i);
        has_above = 1'b1;
      end
    end
  end

  // Next-state and next-output selection; en dominates mode, all defaults describe IDLE.
  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = '0;
    idx_nxt   = '0;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    if (en && !mode) begin
      state_nxt = ST_DIRECT;
      if (mask[s]) begin
        idx_nxt   = s;
        valid_nxt = 1'b1;
      end
    end else if (en && mode) begin
      state_nxt = ST_SCAN;
      if (any_set) begin
        valid_nxt = 1'b1;
        if ((state != ST_SCAN) || !valid) begin
          // Fresh entry, or resuming after the mask went empty: start at the bottom, no wrap.
          idx_nxt = lowest;
        end else if (!mask[idx] || (cnt == dwell)) begin
          // Dwell expired or the active channel was masked off: step to the next enabled one.
          idx_nxt  = has_above ? above : lowest;
          wrap_nxt = !has_above;
        end else begin
          idx_nxt = idx;
          cnt_nxt = cnt + 1'b1;
        end
      end
    end
  end

  // Output and state registers; o is rebuilt from the next index so it always matches idx/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
      o     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      valid <= valid_nxt;
      wrap  <= wrap_nxt;
      o     <= valid_nxt ? (N'(1) << idx_nxt) : '0;
    end
  end

endmodule
